main_memory_model: RTL
======================

Name: main_memory_model

Overview:
- Backing-store stage directly downstream of cache_system_2level; the L2 issues line fills and write-throughs to it on a miss.
- Models main memory with fixed access latency and a multi-word burst return of one aligned cache block.
- Keeps saturating read/write request counters for the simulator's statistics reporting.

Parameters:
- ADDR_WIDTH, 11, word address width.
- DATA_WIDTH, 11, word width.
- LATENCY, 4, cycles from request acceptance to first response beat; must be >=1, and 0 is illegal.
- BLOCK_WORDS, 4, words per burst; must be a power of two and >=1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = single-word write, 0 = block read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read beat valid.
- rsp_data  out  DATA_WIDTH  read beat data.
- rsp_last  out  1  final beat of the burst.
- wr_done  out  1  one-cycle write completion pulse.
- busy  out  1  high in any state other than IDLE.
- rd_count  out  16  accepted reads, saturating.
- wr_count  out  16  accepted writes, saturating.

Behaviour:
- Storage: array of 2^ADDR_WIDTH words, initialised at time zero to word[a] = a (truncated to DATA_WIDTH). Reset does not alter the array.
- All outputs are registered.
  - Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_last=0, wr_done=0, busy=0, rd_count=0, wr_count=0.
  - req_ready rises on the first clk edge after rst deasserts.
- Handshake:
  - A request is accepted on a clk edge with req_valid && req_ready.
  - req_ready is high only in IDLE and drops on the acceptance edge.
  - There is no rsp back-pressure; the consumer must take every beat.
- FSM states: IDLE, WAIT, BURST, WACK.
- IDLE -> WAIT on acceptance. The block latches:
  - base = req_addr with the low log2(BLOCK_WORDS) bits cleared;
  - the op type;
  - latency counter = LATENCY-1.
- Write data commits to the array on the acceptance edge itself.
- WAIT: the counter decrements each cycle. At 0:
  - read -> BURST;
  - write -> WACK.
  - Net timing: first rsp_valid or wr_done is high in the cycle beginning LATENCY edges after the acceptance edge.
- BURST: BLOCK_WORDS consecutive cycles with rsp_valid=1.
  - rsp_data = word[base+i] for i = 0..BLOCK_WORDS-1, ascending.
  - rsp_last=1 only on i = BLOCK_WORDS-1.
  - The index never crosses the block because base is aligned.
  - After the last beat -> IDLE; req_ready is high in the following cycle.
- WACK: wr_done=1 for exactly one cycle -> IDLE.
- rsp_data holds its last value when rsp_valid=0.
- rsp_valid and wr_done are never high in the same cycle.
- Read-after-write: a read accepted after a write's acceptance edge returns the new data.
- Counters: rd_count/wr_count increment on the acceptance edge. Each saturates at 16'hFFFF and holds.
- Reset mid-operation: FSM -> IDLE immediately and all outputs take reset values.
  - An in-flight burst is aborted with no rsp_last.
  - Counters clear.
  - A write already accepted remains committed.
- req_valid while not ready is ignored; it is not queued.
- Counter and index widths are sized by clog2 of LATENCY and BLOCK_WORDS. A LATENCY=1 or BLOCK_WORDS=1 configuration must work.

Test Plan:
- Read at 11'h123, defaults: accept at edge E -> rsp_valid from E+4 for 4 cycles with data 120,121,122,123 (hex); rsp_last on 123; req_ready back after the burst; rd_count=1.
- Write 11'h2A3 <- 11'h055, then read 11'h2A0 -> wr_done pulses 4 cycles after accept; burst returns 2A0,2A1,2A2,055; wr_count=1.
- req_valid held high continuously with reads to 11'h200 then 11'h345 -> second accept only after the first rsp_last; bursts 200..203 and 344..347; no overlap.
- rst asserted during beat 2 of a burst -> rsp_valid drops asynchronously; no rsp_last; req_ready=1 one edge after release; a new read of 11'h123 returns 120..123.
- LATENCY=1, BLOCK_WORDS=1 build, read 11'h201 -> single beat 201 with rsp_last=1 one edge after accept.
- Force rd_count to 16'hFFFE and issue 3 reads -> rd_count stays at FFFF.

Source files
------------

// File: rtl/main_memory_model.sv
// Backing store below the L2: fixed-latency block-burst reads and single-word writes.
// Latency: first beat / wr_done LATENCY cycles after acceptance; one request in flight at a time.
// Backpressure: req_ready low from acceptance until the burst/ack completes; rsp has no backpressure.
module main_memory_model #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 11,
    parameter int LATENCY     = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  wr_done,
    output logic                  busy,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BLOCK_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~OFF_MASK;

    if (LATENCY < 1) begin : g_bad_latency
        $error("main_memory_model: LATENCY must be >= 1");
    end
    if ((BLOCK_WORDS < 1) || ((BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0)) begin : g_bad_block
        $error("main_memory_model: BLOCK_WORDS must be a power of two");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_WACK} state_t;
    typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_t;

    function automatic mem_t f_init();
        for (int a = 0; a < DEPTH; a++) begin
            f_init[a] = DATA_WIDTH'(a);
        end
    endfunction

    // Contents start as word[a] = a and are deliberately untouched by reset.
    mem_t r_mem = f_init();

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_is_wr;
    logic                  w_accept;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic                  w_rsp_vld_nxt;
    logic                  w_rsp_last_nxt;
    logic [DATA_WIDTH-1:0] w_rsp_dat_nxt;
    logic                  w_wr_done_nxt;

    assign w_accept    = req_valid && req_ready;
    assign w_beat_addr = r_base | (ADDR_WIDTH'(r_idx) & OFF_MASK);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_issue        = 1'b0;
        w_wr_done_nxt  = 1'b0;
        w_rsp_vld_nxt  = 1'b0;
        w_rsp_last_nxt = 1'b0;
        w_rsp_dat_nxt  = rsp_data;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_W'(LATENCY - 1);
                    w_idx_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    if (r_is_wr) begin
                        w_state_nxt   = S_WACK;
                        w_wr_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_BURST;
                        w_issue     = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            // rsp_last being high means the final beat is on the bus this cycle.
            S_BURST: begin
                if (rsp_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_issue = 1'b1;
                end
            end
            S_WACK:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_issue) begin
            w_rsp_vld_nxt  = 1'b1;
            w_rsp_dat_nxt  = r_mem[w_beat_addr];
            w_rsp_last_nxt = (r_idx == IDX_W'(BLOCK_WORDS - 1));
            w_idx_nxt      = r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_base    <= '0;
            r_is_wr   <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
            wr_done   <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            req_ready <= (w_state_nxt == S_IDLE);
            busy      <= (w_state_nxt != S_IDLE);
            rsp_valid <= w_rsp_vld_nxt;
            rsp_last  <= w_rsp_last_nxt;
            rsp_data  <= w_rsp_dat_nxt;
            wr_done   <= w_wr_done_nxt;
            if (w_accept) begin
                r_base  <= req_addr & BASE_MASK;
                r_is_wr <= req_write;
                if (req_write) begin
                    if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                end else begin
                    if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                end
            end
        end
    end

    // Commit on the acceptance edge so any later read sees the new word.
    always_ff @(posedge clk) begin
        if (w_accept && req_write) begin
            r_mem[req_addr] <= req_wdata;
        end
    end
endmodule
